// File: rtl/usb_rx_bit_decoder.sv
// USB full-speed receive bit recovery: realigns the bit-period counter on
// each D+ transition, samples near mid-bit, NRZI-decodes, strips stuffed
// bits and assembles LSB-first bytes.
module usb_rx_bit_decoder #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_POINT = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus_sync,
  input  logic       edge_detect,
  input  logic       rcving,
  output logic       rx_bit,
  output logic       bit_valid,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       stuff_error
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    RUN
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [2:0]     ones, ones_nx;
  logic [2:0]     bit_idx, bit_idx_nx;
  logic [7:0]     shreg, shreg_nx;
  logic           prev, prev_nx;
  logic           rx_bit_nx, bit_valid_nx, byte_valid_nx, stuff_error_nx;
  logic [7:0]     rx_byte_nx;
  logic           dec;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ones        <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      prev        <= 1'b1;
      rx_bit      <= 1'b0;
      bit_valid   <= 1'b0;
      rx_byte     <= '0;
      byte_valid  <= 1'b0;
      stuff_error <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ones        <= ones_nx;
      bit_idx     <= bit_idx_nx;
      shreg       <= shreg_nx;
      prev        <= prev_nx;
      rx_bit      <= rx_bit_nx;
      bit_valid   <= bit_valid_nx;
      rx_byte     <= rx_byte_nx;
      byte_valid  <= byte_valid_nx;
      stuff_error <= stuff_error_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    ones_nx        = ones;
    bit_idx_nx     = bit_idx;
    shreg_nx       = shreg;
    prev_nx        = prev;
    rx_bit_nx      = rx_bit;
    rx_byte_nx     = rx_byte;
    bit_valid_nx   = 1'b0;
    byte_valid_nx  = 1'b0;
    stuff_error_nx = 1'b0;
    dec            = 1'b0;

    if (!rcving) begin
      // dropping rcving also cancels any pulse due next cycle
      state_nx   = IDLE;
      cnt_nx     = '0;
      ones_nx    = '0;
      bit_idx_nx = '0;
      shreg_nx   = '0;
      prev_nx    = 1'b1;
    end else begin
      case (state)
        IDLE: state_nx = WAIT_EDGE;
        WAIT_EDGE: begin
          if (edge_detect) begin
            state_nx = RUN;
            cnt_nx   = '0;
          end
        end
        RUN: begin
          if (edge_detect) begin
            // an edge on the sample cycle takes priority; no sample then
            cnt_nx = '0;
          end else begin
            cnt_nx = (cnt == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt + CW'(1);
            if (cnt == CW'(SAMPLE_POINT)) begin
              dec     = (d_plus_sync == prev);
              prev_nx = d_plus_sync;
              if (ones == 3'd6) begin
                ones_nx        = '0;
                stuff_error_nx = dec;
              end else begin
                ones_nx      = dec ? ones + 3'd1 : 3'd0;
                rx_bit_nx    = dec;
                bit_valid_nx = 1'b1;
                shreg_nx     = {dec, shreg[7:1]};
                bit_idx_nx   = bit_idx + 3'd1;
                if (bit_idx == 3'd7) begin
                  rx_byte_nx    = {dec, shreg[7:1]};
                  byte_valid_nx = 1'b1;
                end
              end
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule
